// File: rtl/cis_pkg.sv
// Shared types and constants for the CIS skipper readout blocks.
package cis_pkg;

    localparam int unsigned DEFAULT_ADC_W              = 16;
    localparam int unsigned DEFAULT_ACC_W              = 27;
    localparam int unsigned DEFAULT_PIXEL_CLUSTER_SIZE = 16;

    // Width of the pixel index for the default cluster size.
    localparam int unsigned PIX_IDX_W = $clog2(DEFAULT_PIXEL_CLUSTER_SIZE);

    // Width of the per-pixel sample count (skip_samples, out_nsamp).
    localparam int unsigned NSAMP_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBase,
        StArmBase,
        StWaitSig,
        StArmSig
    } acc_state_e;

    // A requested sample count of zero still takes one pair.
    function automatic logic [NSAMP_W-1:0] eff_nsamp(input logic [NSAMP_W-1:0] skip);
        return (skip == '0) ? NSAMP_W'(1) : skip;
    endfunction

endpackage

// File: rtl/skipper_sample_accumulator_if.sv
// Result port of the skipper sample accumulator: one CDS sum per pixel on valid/ready.
interface skipper_sample_accumulator_if
    import cis_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W,
    parameter int unsigned PIX_W = PIX_IDX_W
);

    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [PIX_W-1:0]        out_pixel;
    logic [NSAMP_W-1:0]      out_nsamp;

    modport master (
        output out_valid,
        output out_data,
        output out_pixel,
        output out_nsamp,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_pixel,
        input  out_nsamp,
        output out_ready
    );

endinterface

// File: rtl/phi_edge_detect.sv
// Registered rising-edge detection for the two sequencer strobes.
// Edges appear one cycle after the rising level; both_rise flags a coincident pair.
module phi_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic phi1,
    input  logic phi2,
    output logic phi1_rise,
    output logic phi2_rise,
    output logic both_rise
);

    logic phi1_q;
    logic phi2_q;

    // Delay the strobe levels and register their rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi1_q    <= 1'b0;
            phi2_q    <= 1'b0;
            phi1_rise <= 1'b0;
            phi2_rise <= 1'b0;
            both_rise <= 1'b0;
        end else begin
            phi1_q    <= phi1;
            phi2_q    <= phi2;
            phi1_rise <= phi1 & ~phi1_q;
            phi2_rise <= phi2 & ~phi2_q;
            both_rise <= (phi1 & ~phi1_q) & (phi2 & ~phi2_q);
        end
    end

endmodule

// File: rtl/skipper_sample_accumulator.sv
// Captures baseline/signal ADC words on the sequencer strobes, accumulates
// (signal - baseline) over the skip repetitions of a pixel and presents one
// signed sum per pixel with its index on a valid/ready port.
module skipper_sample_accumulator
    import cis_pkg::*;
#(
    parameter int unsigned ADC_W              = DEFAULT_ADC_W,
    parameter int unsigned ACC_W              = DEFAULT_ACC_W,
    parameter int unsigned PIXEL_CLUSTER_SIZE = DEFAULT_PIXEL_CLUSTER_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic [NSAMP_W-1:0]   skip_samples,
    input  logic                 phi1,
    input  logic                 phi2,
    input  logic                 adc_valid,
    input  logic [ADC_W-1:0]     adc_data,
    input  logic                 clear_status,
    output logic                 overflow,
    output logic                 seq_error,
    skipper_sample_accumulator_if.master out_if
);

    localparam int unsigned PixW = $clog2(PIXEL_CLUSTER_SIZE);
    localparam logic [PixW-1:0] PixLast = PixW'(PIXEL_CLUSTER_SIZE - 1);

    // Edge detector outputs.
    logic phi1_rise;
    logic phi2_rise;
    logic both_rise;

    // Sequencer and accumulator state.
    acc_state_e              state_q, state_d;
    logic [NSAMP_W-1:0]      n_q, n_d;
    logic [NSAMP_W-1:0]      cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ADC_W-1:0]        base_q, base_d;
    logic [PixW-1:0]         pix_q, pix_d;

    // Output register and sticky status.
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [PixW-1:0]         out_pixel_q, out_pixel_d;
    logic [NSAMP_W-1:0]      out_nsamp_q, out_nsamp_d;
    logic                    overflow_q, overflow_d;
    logic                    seq_error_q, seq_error_d;

    // Datapath helpers.
    logic signed [ADC_W:0]   diff;
    logic signed [ACC_W-1:0] diff_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [NSAMP_W-1:0]      cnt_inc;
    logic [PixW-1:0]         pix_next;
    logic                    final_sample;
    logic                    issue;
    logic                    seq_set;
    logic                    out_load;
    logic                    drop;

    phi_edge_detect u_phi_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .phi1      (phi1),
        .phi2      (phi2),
        .phi1_rise (phi1_rise),
        .phi2_rise (phi2_rise),
        .both_rise (both_rise)
    );

    // Per-pair difference, the running sum including it, and the final-pair test.
    always_comb begin
        diff         = $signed({1'b0, adc_data}) - $signed({1'b0, base_q});
        diff_ext     = {{(ACC_W - ADC_W - 1){diff[ADC_W]}}, diff};
        acc_sum      = acc_q + diff_ext;
        cnt_inc      = cnt_q + NSAMP_W'(1);
        pix_next     = (pix_q == PixLast) ? '0 : pix_q + PixW'(1);
        final_sample = (state_q == StArmSig) && adc_valid && !both_rise && (cnt_inc == n_q);
    end

    // Sequencer next state: frame_start, then enable abort, then coincident edges.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        base_d  = base_q;
        pix_d   = pix_q;
        seq_set = 1'b0;
        issue   = 1'b0;

        if (frame_start) begin
            // Any pixel in progress, including a coincident final sample, is discarded.
            state_d = StIdle;
            pix_d   = '0;
        end else if (state_q == StIdle) begin
            if (enable) begin
                n_d     = eff_nsamp(skip_samples);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StWaitBase;
            end
        end else if (!enable && !final_sample) begin
            state_d = StIdle;
        end else if (both_rise) begin
            seq_set = 1'b1;
        end else begin
            unique case (state_q)
                StWaitBase: begin
                    if (phi1_rise) begin
                        state_d = StArmBase;
                    end else if (phi2_rise) begin
                        seq_set = 1'b1;
                    end
                end
                StArmBase: begin
                    if (adc_valid) begin
                        base_d  = adc_data;
                        state_d = StWaitSig;
                    end else if (phi2_rise) begin
                        seq_set = 1'b1;
                    end
                end
                StWaitSig: begin
                    if (phi2_rise) begin
                        state_d = StArmSig;
                    end else if (phi1_rise) begin
                        // Re-capture the baseline; pairs already summed are kept.
                        seq_set = 1'b1;
                        state_d = StArmBase;
                    end
                end
                StArmSig: begin
                    if (adc_valid) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        if (final_sample) begin
                            issue = 1'b1;
                            pix_d = pix_next;
                            acc_d = '0;
                            cnt_d = '0;
                            if (enable) begin
                                n_d     = eff_nsamp(skip_samples);
                                state_d = StWaitBase;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            state_d = StWaitBase;
                        end
                    end else if (phi1_rise) begin
                        seq_set = 1'b1;
                        state_d = StArmBase;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output register load/hold and sticky flags; a same-cycle set beats clear.
    always_comb begin
        out_load    = issue && (!out_valid_q || out_if.out_ready);
        drop        = issue && !out_load;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_pixel_d = out_pixel_q;
        out_nsamp_d = out_nsamp_q;

        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_sum;
            out_pixel_d = pix_q;
            out_nsamp_d = n_q;
        end else if (out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        overflow_d  = drop    ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
        seq_error_d = seq_set ? 1'b1 : (clear_status ? 1'b0 : seq_error_q);
    end

    // Sequencer and accumulator state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            pix_q   <= pix_d;
        end
    end

    // Output and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pixel_q <= '0;
            out_nsamp_q <= '0;
            overflow_q  <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pixel_q <= out_pixel_d;
            out_nsamp_q <= out_nsamp_d;
            overflow_q  <= overflow_d;
            seq_error_q <= seq_error_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_pixel = out_pixel_q;
    assign out_if.out_nsamp = out_nsamp_q;
    assign overflow         = overflow_q;
    assign seq_error        = seq_error_q;

endmodule

// File: doc/skipper_sample_accumulator.md
Name: skipper_sample_accumulator

Overview:
- Receive-side companion to the CIS pattern sequencer, sitting between the ADC and the readout datapath.
- Watches the sprocket_phi1 (baseline) and sprocket_phi2 (signal) sample strobes produced by the sequencer and captures the matching ADC words.
- Accumulates (signal − baseline) over the skip_samples repetitions of one pixel.
- Presents one signed correlated-double-sample sum per pixel, with pixel index, on a valid/ready port.

Parameters:
- ADC_W, 16, ADC word width (unsigned).
- ACC_W, 27, accumulator width. Must be ≥ ADC_W+11, which is sign + 10-bit count headroom.
- PIXEL_CLUSTER_SIZE, 16, number of pixel indices before out_pixel wraps.

Ports:
- clk  in  1  single clock. Every input is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  accumulation enable.
- frame_start  in  1  one-cycle pulse. Clears the pixel index and aborts any pixel in progress.
- skip_samples  in  10  samples per pixel. The value 0 is treated as 1.
- phi1  in  1  baseline strobe from the sequencer (level).
- phi2  in  1  signal strobe from the sequencer (level).
- adc_valid  in  1  adc_data qualifier.
- adc_data  in  ADC_W  unsigned ADC word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  signed sum of (sig−base).
- out_pixel  out  $clog2(PIXEL_CLUSTER_SIZE)  pixel index of the result.
- out_nsamp  out  10  number of pairs in the sum.
- clear_status  in  1  pulse. Clears the sticky flags.
- overflow  out  1  sticky: a result was dropped because the output was occupied.
- seq_error  out  1  sticky: phi strobe arrived out of order.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, pixel index 0, phi edge registers 0.
- Edge detection:
  - phi1_rise = phi1 & ~phi1_q; phi2_rise likewise.
  - Registered edges are used one cycle after the rising level appears.
- States: IDLE, WAIT_BASE, ARM_BASE, WAIT_SIG, ARM_SIG.
- IDLE:
  - If enable: latch n = max(skip_samples,1), clear acc and pair count, go to WAIT_BASE.
- WAIT_BASE:
  - phi1_rise → ARM_BASE.
  - phi2_rise → set seq_error, stay.
- ARM_BASE:
  - The first adc_valid loads base; go to WAIT_SIG.
  - phi2_rise before that sample → seq_error, stay.
- WAIT_SIG:
  - phi2_rise → ARM_SIG.
  - phi1_rise → seq_error, go to ARM_BASE (re-capture baseline; pair count unchanged).
- ARM_SIG:
  - The first adc_valid computes acc += zext(adc_data) − zext(base), sign-extended to ACC_W, and increments the pair count.
  - If count == n: issue the result, then go to IDLE if enable is low, else re-latch n and go to WAIT_BASE with acc cleared.
  - If count < n: go to WAIT_BASE.
  - phi1_rise before the sample → seq_error, go to ARM_BASE.
- Simultaneous phi1_rise and phi2_rise in any active state: seq_error, both ignored, state held.
- Result issue:
  - If !out_valid, or out_valid & out_ready in the same cycle: the next cycle shows out_valid=1, out_data=final acc (including the last pair), out_pixel=index, out_nsamp=n.
  - Latency: 1 cycle from the final signal sample.
  - Otherwise the result is dropped and overflow is set.
  - The pixel index increments in both cases, wrapping from PIXEL_CLUSTER_SIZE−1 to 0.
- Output register:
  - out_valid holds until out_ready. Data is stable while valid.
  - out_valid falls on accept unless a new result loads in the same cycle.
- enable low in any non-IDLE state: abort to IDLE next cycle, no result, index unchanged.
- frame_start:
  - Index ← 0 and abort to IDLE.
  - The output register is unaffected.
  - frame_start takes priority over a coincident final sample; that sample is discarded.
- clear_status clears overflow and seq_error. A same-cycle set wins over clear.
- Mid-operation reset_n low: immediate return to reset values.

Decomposition:
- Shared package cis_pkg: the state enum type and the derived width constant PIX_IDX_W = $clog2(PIXEL_CLUSTER_SIZE).
- One natural sub-module: phi_edge_detect (two-channel rising-edge registers with a coincident-edge flag).
- The accumulator and output register stay inline.

Test Plan:
- skip_samples=3, pairs (base,sig) = (100,150), (200,180), (50,60) → one result with out_data=+40, out_nsamp=3, out_pixel=0, out_valid 1 cycle after the third sig sample.
- skip_samples=0, one pair (1000,10) → out_data=−990, out_nsamp=1.
- 17 consecutive pixels with out_ready=1 → out_pixel runs 0..15 then 0. frame_start mid-pixel 5 → no result for that pixel; next out_pixel=0.
- out_ready=0 across two pixel completions → first result held stable, second dropped, overflow=1. clear_status → overflow=0.
- phi2 pulse before phi1 → seq_error=1, no capture. phi1, phi1, phi2 with samples 10, 20, 25 → baseline=20, out_data=+5.
- skip_samples=1023, base=65535, sig=0 on every pair → out_data=−67,042,305 with no wrap. enable dropped mid-pixel → no output, state IDLE.
